// File: rtl/vga_fetch_pkg.sv
// Shared widths and FSM encoding for the VGA CSR scanline prefetch engine.
package vga_fetch_pkg;
  localparam int ADR_W = 17;
  localparam int DAT_W = 16;
  localparam int LEN_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/vga_fetch_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on dout_o whenever not empty.
module vga_fetch_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_pop;

  assign w_pop = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wp] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push_i) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({push_i, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign count_o = r_cnt;
  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == (AW+1)'(DEPTH));
  // Storage is not reset, so the head is masked to keep stale words off the port.
  assign dout_o  = empty_o ? '0 : r_mem[r_rp];
endmodule

// File: rtl/vga_csr_fetch.sv
// Scanline prefetch: credit-limited burst of CSR word reads, fixed-latency
// capture into a show-ahead FIFO drained by the pixel serializer.
module vga_csr_fetch
  import vga_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LAT     = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [ADR_W-1:0] base_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ADR_W-1:0] csr_adr_o,
  output logic             csr_stb_o,
  input  logic [DAT_W-1:0] csr_dat_i,
  output logic [DAT_W-1:0] pix_dat_o,
  output logic             pix_valid_o,
  input  logic             pix_ready_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = 16;
  localparam logic [RD_LAT-1:0] TAIL = RD_LAT'(1) << (RD_LAT - 1);

  fetch_state_t      r_state;
  logic [ADR_W-1:0]  r_adr;
  logic [LEN_W-1:0]  r_len, r_cnt;
  logic              r_stb, r_busy, r_done;
  logic [RD_LAT-1:0] r_vld;

  logic [CW-1:0] w_count;
  logic          w_empty, w_full, w_push, w_pop;
  logic          w_want, w_credit, w_issue, w_last;
  logic [SW-1:0] w_infl, w_need;

  assign w_push      = r_vld[RD_LAT-1];
  assign pix_valid_o = ~w_empty;
  assign w_pop       = pix_valid_o & pix_ready_i;

  always_comb begin
    w_infl = '0;
    for (int i = 0; i < RD_LAT; i++) w_infl = w_infl + SW'(r_vld[i]);
  end

  // Occupancy as seen next cycle (buffered + in flight incl. current strobe, less
  // this cycle's pop) plus the strobe being decided must fit in the FIFO.
  assign w_need   = SW'(w_count) + w_infl + SW'(r_stb) + SW'(1) - SW'(w_pop);
  assign w_credit = (w_need <= SW'(FIFO_DEPTH)) && !(w_full && !w_pop);
  assign w_want   = ((r_state == IDLE) && start_i && (len_i != '0)) ||
                    ((r_state == FETCH) && (r_cnt != r_len));
  assign w_issue  = w_want && w_credit;
  // Only the tail (pushing this edge) may remain, so done lands right after the last push.
  assign w_last   = ((r_vld & ~TAIL) == '0) && !r_stb;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_adr   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_stb   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_vld   <= '0;
    end else begin
      r_stb  <= w_issue;
      r_done <= 1'b0;
      r_vld  <= (r_vld << 1) | RD_LAT'(r_stb);
      if (r_stb) r_adr <= r_adr + ADR_W'(1);
      case (r_state)
        IDLE: if (start_i) begin
          r_adr   <= base_adr_i;
          r_len   <= len_i;
          r_cnt   <= LEN_W'(w_issue);
          r_busy  <= 1'b1;
          r_state <= (len_i == '0) ? DRAIN : FETCH;
        end
        FETCH: begin
          r_cnt <= r_cnt + LEN_W'(w_issue);
          if (r_cnt == r_len) r_state <= DRAIN;
        end
        DRAIN: if (w_last) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  vga_fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DAT_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .din_i   (csr_dat_i),
    .pop_i   (w_pop),
    .dout_o  (pix_dat_o),
    .count_o (w_count),
    .empty_o (w_empty),
    .full_o  (w_full)
  );

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign csr_adr_o = r_adr;
  assign csr_stb_o = r_stb;
endmodule

// File: tb/tb_vga_csr_fetch.sv
// Randomized bench for vga_csr_fetch: memory model with fixed latency, address
// and data scoreboards, plus directed timing checks around start/done/reset.
module tb_vga_csr_fetch;
  localparam int DEPTH = 8;
  localparam int RL    = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [16:0] base_adr_i = '0;
  logic [9:0]  len_i = '0;
  logic [15:0] csr_dat_i = '0;
  logic        pix_ready_i = 1'b0;
  logic        busy_o, done_o, csr_stb_o, pix_valid_o;
  logic [16:0] csr_adr_o;
  logic [15:0] pix_dat_o;

  always #5 clk_i = ~clk_i;

  vga_csr_fetch #(.FIFO_DEPTH(DEPTH), .RD_LAT(RL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_adr_i(base_adr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .csr_adr_o(csr_adr_o),
    .csr_stb_o(csr_stb_o), .csr_dat_i(csr_dat_i), .pix_dat_o(pix_dat_o),
    .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i)
  );

  int n_chk = 0, n_bad = 0, n_stb = 0, n_done = 0;
  logic [16:0] exp_adr[$];
  logic [15:0] exp_dat[$];
  bit          hv[0:RL];
  logic [16:0] ha[0:RL];
  logic        tr_stb[1:16], tr_vld[1:16], tr_done[1:16], tr_busy[1:16];

  function automatic logic [15:0] memf(input logic [16:0] a);
    return a[15:0] ^ {a[16], 15'h2A5B};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Memory returns data RL cycles after each strobe; garbage otherwise.
  always @(negedge clk_i) begin
    for (int k = RL; k > 0; k--) begin hv[k] = hv[k-1]; ha[k] = ha[k-1]; end
    hv[0] = csr_stb_o;
    ha[0] = csr_adr_o;
    csr_dat_i = hv[RL] ? memf(ha[RL]) : 16'($urandom);
    if (!rst_i) begin
      exp_adr.delete();
      exp_dat.delete();
    end else begin
      if (csr_stb_o) begin
        n_stb++;
        chk("stb_expected", 32'(exp_adr.size() != 0), 32'd1);
        if (exp_adr.size() != 0) chk("stb_adr", 32'(csr_adr_o), 32'(exp_adr.pop_front()));
      end
      if (pix_valid_o && pix_ready_i) begin
        chk("pop_expected", 32'(exp_dat.size() != 0), 32'd1);
        if (exp_dat.size() != 0) chk("pix_dat", 32'(pix_dat_o), 32'(exp_dat.pop_front()));
      end
      if (done_o) n_done++;
      if (dut.w_push) chk("no_ovf", 32'(dut.w_full & ~dut.w_pop), 32'd0);
    end
  end

  task automatic start(input logic [16:0] b, input logic [9:0] l, input bit acc);
    start_i = 1'b1; base_adr_i = b; len_i = l;
    if (acc) for (int i = 0; i < int'(l); i++) begin
      exp_adr.push_back(b + 17'(i));
      exp_dat.push_back(memf(b + 17'(i)));
    end
    @(posedge clk_i); #1;
    start_i = 1'b0; base_adr_i = 17'($urandom); len_i = 10'($urandom);
  endtask

  task automatic trace(input int n);
    for (int r = 1; r <= n; r++) begin
      tr_stb[r] = csr_stb_o; tr_vld[r] = pix_valid_o;
      tr_done[r] = done_o;   tr_busy[r] = busy_o;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic run_until_done(input int maxc, input int mode);
    bit seen = 1'b0;
    for (int c = 0; c < maxc && !seen; c++) begin
      pix_ready_i = (mode == 2) ? 1'($urandom) : 1'(mode);
      @(posedge clk_i); #1;
      if (done_o) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic drain();
    pix_ready_i = 1'b1;
    for (int c = 0; c < 100 && (exp_dat.size() != 0 || pix_valid_o); c++) begin
      @(posedge clk_i); #1;
    end
    chk("drain_left", 32'(exp_dat.size()), 32'd0);
    chk("drain_valid", 32'(pix_valid_o), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_stb"},  32'(csr_stb_o), 32'd0);
    chk({tag, "_adr"},  32'(csr_adr_o), 32'd0);
    chk({tag, "_vld"},  32'(pix_valid_o), 32'd0);
    chk({tag, "_dat"},  32'(pix_dat_o), 32'd0);
  endtask

  initial begin
    int d, dn, q;
    logic [16:0] b;
    logic [9:0]  l;
    #2 rst_i = 1'b0;
    repeat (3) @(posedge clk_i); #1;
    chk_reset_outs("rst");
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Basic line, consumer always ready: exact cycle timing relative to start.
    pix_ready_i = 1'b1;
    start(17'h00100, 10'd4, 1'b1);
    trace(12);
    for (int r = 1; r <= 12; r++) begin
      chk("s1_stb",  32'(tr_stb[r]),  32'(r <= 4));
      chk("s1_vld",  32'(tr_vld[r]),  32'(r >= RL + 2 && r <= 4 + RL + 1));
      chk("s1_done", 32'(tr_done[r]), 32'(r == 4 + RL + 1));
      chk("s1_busy", 32'(tr_busy[r]), 32'(r <= 4 + RL));
    end
    chk("s1_left", 32'(exp_dat.size()), 32'd0);

    // Stalled consumer: credit caps outstanding words at DEPTH.
    d = n_stb;
    pix_ready_i = 1'b0;
    start(17'($urandom), 10'd20, 1'b1);
    repeat (25) @(posedge clk_i); #1;
    chk("s2_stall_stb", 32'(n_stb - d), 32'(DEPTH));
    chk("s2_vld_held", 32'(pix_valid_o), 32'd1);
    run_until_done(300, 1);
    chk("s2_total_stb", 32'(n_stb - d), 32'd20);
    drain();

    // Address wrap at the top of the 17-bit space.
    d = n_stb;
    start(17'h1FFFE, 10'd4, 1'b1);
    run_until_done(300, 2);
    chk("s3_stb", 32'(n_stb - d), 32'd4);
    drain();

    // Zero-length line.
    d = n_stb;
    start(17'h00AAA, 10'd0, 1'b1);
    trace(5);
    for (int r = 1; r <= 5; r++) begin
      chk("s4_busy", 32'(tr_busy[r]), 32'(r == 1));
      chk("s4_done", 32'(tr_done[r]), 32'(r == 2));
    end
    chk("s4_nostb", 32'(n_stb - d), 32'd0);

    // Start re-pulsed mid-fetch must be ignored.
    d = n_stb; dn = n_done;
    b = 17'($urandom);
    pix_ready_i = 1'b1;
    start(b, 10'd6, 1'b1);
    @(posedge clk_i); #1;
    start(b ^ 17'h0F0F0, 10'd3, 1'b0);
    run_until_done(200, 1);
    repeat (3) @(posedge clk_i); #1;
    chk("s5_ndone", 32'(n_done - dn), 32'd1);
    chk("s5_nstb", 32'(n_stb - d), 32'd6);
    chk("s5_adr", 32'(csr_adr_o), 32'(b + 17'd6));
    drain();

    // Reset with two reads in flight: outputs clear at once, late data ignored.
    start(17'h01230, 10'd8, 1'b1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1 chk_reset_outs("s6");
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    q = 0;
    for (int c = 0; c < 8; c++) begin
      q += int'(pix_valid_o) + int'(busy_o) + int'(csr_stb_o);
      @(posedge clk_i); #1;
    end
    chk("s6_quiet", 32'(q), 32'd0);

    // Random lines, random backpressure, sometimes starting over residual words.
    for (int i = 0; i < 6; i++) begin
      d = n_stb;
      b = 17'($urandom);
      l = 10'(1 + $urandom_range(0, 39));
      start(b, l, 1'b1);
      run_until_done(3000, 2);
      chk("s7_stb", 32'(n_stb - d), 32'(l));
      if (i % 2 == 1) drain();
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_csr_fetch.md
# vga_csr_fetch

Scanline prefetch engine for the VGA core's frame-read (CSR) path. On a start pulse it issues a burst of sequential 16-bit word reads to the memory arbiter's CSR port. It captures each word after a fixed read latency and buffers it in a small FIFO. The downstream pixel serializer pops words through a valid/ready handshake. It sits directly upstream of the memory arbiter's CSR port, in the `clk_i` domain.

## Interface
- `FIFO_DEPTH`, 8: word buffer depth; power of two, ≥ 4.
- `RD_LAT`, 2: cycles from a strobe cycle to the cycle in which `csr_dat_i` is valid; ≥ 1.
- `clk_i` in 1: VGA clock; the single clock of this block.
- `rst_i` in 1: reset, asynchronous, active-low; all state is cleared while low.
- `start_i` in 1: one-cycle pulse that starts a line fetch.
- `base_adr_i` in 17: first word address `[17:1]`, sampled on the accepted `start_i`.
- `len_i` in 10: number of words to fetch, 0–1023, sampled on the accepted `start_i`.
- `busy_o` out 1: high from the accepted start until `done_o`.
- `done_o` out 1: one-cycle pulse when the last word has been written into the FIFO.
- `csr_adr_o` out 17: read word address.
- `csr_stb_o` out 1: read strobe. One word is read per high cycle; there is no ack.
- `csr_dat_i` in 16: read data, valid `RD_LAT` cycles after the strobe cycle.
- `pix_dat_o` out 16: head-of-FIFO word (show-ahead).
- `pix_valid_o` out 1: FIFO is not empty.
- `pix_ready_i` in 1: consumer accepts `pix_dat_o` in this cycle.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - A `start_i` pulse latches the address and length.
  - With `len_i` = 0: go straight to DRAIN; `done_o` fires on the next cycle and no strobe is issued.
  - Otherwise go to FETCH.
- FETCH:
  - Each cycle, assert `csr_stb_o` if credit allows, i.e. `fifo_count + in_flight + 1 ≤ FIFO_DEPTH`.
  - On each strobe, increment `csr_adr_o`. The address wraps modulo 2^17 (0x1FFFF → 0x00000).
  - Count issued strobes. When the count equals `len`, go to DRAIN.
- DRAIN:
  - Wait until `in_flight` = 0.
  - Pulse `done_o` and drop `busy_o` in the same cycle, then go to IDLE.
- In-flight tracking:
  - An `RD_LAT`-deep valid shift register is loaded with `csr_stb_o`.
  - When its tail bit is set, `csr_dat_i` is pushed into the FIFO.
- `start_i` while `busy_o` = 1 is ignored.
- The FIFO is not flushed by start or done. Residual words stay available to the consumer.
- Pop happens when `pix_valid_o & pix_ready_i`. A push and a pop in the same cycle leave the count unchanged.
- The credit rule guarantees no overflow. A push while full is a design error and gets an assertion in the bench.

## Timing
- Reset values:
  - `busy_o` = 0, `done_o` = 0, `csr_stb_o` = 0, `csr_adr_o` = 0.
  - `pix_valid_o` = 0, `pix_dat_o` = 0.
  - FIFO is empty, shift register is cleared, state is IDLE.
- All outputs are registered except `pix_dat_o` and `pix_valid_o`, which decode directly from FIFO state.
- Start accepted at edge t:
  - The first `csr_stb_o` is high in cycle t+1, with `csr_adr_o` = `base_adr_i`.
  - The first word is pushed at the end of cycle t+1+`RD_LAT`.
  - `pix_valid_o` rises in cycle t+2+`RD_LAT`.
- Throughput is one word per cycle while credit is available.
- With a consumer that is always ready and `FIFO_DEPTH` ≥ `RD_LAT`+2, a line of N words strobes on N consecutive cycles.
- `done_o` is high in the cycle after the last push.
- If reset asserts mid-fetch, everything clears immediately: the strobe drops and buffered words are discarded. Any late data returning from memory is ignored.

## Structure
- Package `vga_fetch_pkg`:
  - Constants `ADR_W`=17, `DAT_W`=16, `LEN_W`=10.
  - State enum `fetch_state_t` {IDLE, FETCH, DRAIN}.
- Sub-module `vga_fetch_fifo`:
  - Parameterised show-ahead synchronous FIFO (DEPTH, WIDTH).
  - Ports: push, pop, count, empty, full.
  - Same clock and reset as the parent.
- The top level holds the FSM, address and length counters, the latency shift register and the credit logic.

## Test plan
- Reset, then start with base 0x00100, len 4, `pix_ready_i`=1:
  - Strobes on 4 consecutive cycles with addresses 0x00100–0x00103.
  - Words appear in order on the pixel port.
  - `done_o` fires once, 1 cycle after the 4th push.
- `pix_ready_i`=0, len 20, DEPTH 8:
  - Exactly 8 strobes, then the strobe stalls and `pix_valid_o` stays 1.
  - Releasing ready resumes the strobes.
  - All 20 words arrive in order with no loss.
- Base 0x1FFFE, len 4:
  - Addresses are 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- len 0:
  - No strobe; `done_o` 1 cycle after start; `busy_o` high for exactly 1 cycle.
- `start_i` re-pulsed during FETCH:
  - Ignored; address and length stay unchanged; a single `done_o`.
- Reset asserted while 2 reads are in flight:
  - All outputs take their reset values immediately.
  - After release, no spurious push from the cancelled reads.
